alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue/writeback sequencer sitting on the operand side of the MiniMicro ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's instruction/num1/num2 inputs, captures the registered result and flags one clock later, and writes the result back. The block is the producer of the ALU's inputs and the consumer of its outputs.

## Interface
Parameters:
- NREGS, 8: register file depth; index width is $clog2(NREGS).
- DATA_W, 32: register and operand width; must equal the ALU operand width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  block can accept a request.
- req_op  in  5  ALU opcode (1..18 legal).
- req_rd, req_rn, req_rm  in  $clog2(NREGS)  destination, operand-1 and operand-2 register indices.
- req_imm_en  in  1  use immediate as operand 2 (see Configuration).
- req_imm  in  8  immediate, zero-extended to DATA_W.
- alu_instruction  out  5  to ALU instruction input.
- alu_num1, alu_num2  out  DATA_W  to ALU operands.
- alu_result  in  DATA_W  registered ALU result.
- alu_flags  in  4  registered ALU flags {V,C,Z,N} (bit0 = N).
- done_valid  out  1  one-cycle completion pulse.
- done_rd  out  $clog2(NREGS)  destination of completed op.
- done_data  out  DATA_W  result of completed op.
- done_err  out  1  completed op was illegal.
- apsr  out  4  architectural flag copy.
- wr_en, wr_addr, wr_data  in  1/idx/DATA_W  external register load port.
- dbg_addr  in  idx; dbg_data  out  DATA_W  combinational register read.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: req_ready=1, alu_instruction=0. On req_valid: latch op, rd and imm_en; read regs[rn] into opA; read regs[rm] (or the zero-extended imm) into opB; go to ISSUE.
- ISSUE: req_ready=0; drive alu_instruction=op (0 if illegal), alu_num1=opA, alu_num2=opB; go to CAPTURE.
- CAPTURE: done_valid=1, done_rd=rd, done_data=alu_result, done_err=illegal; apsr<=alu_flags; go to IDLE.
- Writeback at the CAPTURE edge to regs[rd] for ops 1..17. There is no writeback for op 18 (CMP) or for illegal ops.
- Illegal ops (0, 19..31): accepted; the ALU sees instruction 0; no writeback; apsr unchanged; done_err=1.
- Outside ISSUE, alu_instruction=0 so the ALU holds its flags; the ALU carry therefore persists between ADCS/SBCS ops.
- External write: regs[wr_addr]<=wr_data whenever wr_en is high, in any state. If it hits the same register as a CAPTURE writeback, the ALU writeback wins.
- Operand read in IDLE sees all writes completed at earlier edges; no bypass of same-edge writes is needed.

## Timing
- Request accepted at edge E0. ALU instruction is driven in cycle E0..E1. The ALU registers at E1. done_valid is high in cycle E1..E2. Writeback and apsr update occur at E2. req_ready returns in the cycle after E2.
- Latency is 2 cycles from accept to done_valid. Throughput is one op per 3 cycles.
- Reset values: state IDLE, all regs 0, apsr 0, req_ready 1, done_* 0, alu_instruction/num1/num2 0.
- Reset mid-operation aborts immediately: no writeback, no done pulse.
- req_* fields are sampled only at accept; they may change afterwards.

## Configuration
- ALU_ISSUE_IMM_EN defined: req_imm_en=1 selects {24'b0, req_imm} as operand 2.
- ALU_ISSUE_IMM_EN undefined: req_imm_en and req_imm are ignored; operand 2 is always regs[rm]. The ports remain present.

## Test plan
- Reset, wr r1=0x0000_000F, r2=0x0000_00F0; ORRS rd=3, rn=1, rm=2 -> done_valid 2 cycles after accept, done_data=0xFF, dbg r3=0xFF, apsr=0000.
- SUB rd=4 with r1=5, r2=5 -> r4=0, apsr Z=1, C=1; then CMP rn=1, rm=2 -> no write to rd, apsr Z=1, done_err=0.
- ADDS with r1=0xFFFF_FFFF, r2=1 -> r3=0, C=1, Z=1; then ADCS with r1=0, r2=0 -> r3=1 (carry held across idle cycles).
- req_op=0 and req_op=25 -> done_err=1, destination unchanged, apsr unchanged.
- With ALU_ISSUE_IMM_EN: ADDS rn=1 (0x10), imm=0x22, imm_en=1 -> 0x32. Without the macro: the same stimulus uses regs[rm].
- Assert rst during ISSUE -> no done pulse, all regs 0; wr_en to rd coincident with CAPTURE -> ALU result retained.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback sequencer that feeds the MiniMicro ALU from a local register file.
// Define ALU_ISSUE_IMM_EN to let req_imm_en select the zero-extended req_imm as operand 2.
module alu_issue_ctrl #(
    parameter int  NREGS  = 8,
    parameter int  DATA_W = 32,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic [IDX_W-1:0]  req_rn,
    input  logic [IDX_W-1:0]  req_rm,
    input  logic              req_imm_en,
    input  logic [7:0]        req_imm,
    output logic [4:0]        alu_instruction,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              done_valid,
    output logic [IDX_W-1:0]  done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              done_err,
    output logic [3:0]        apsr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // state   | meaning
    // IDLE    | ready for a request; operands are read on accept
    // ISSUE   | opcode and operands presented to the ALU
    // CAPTURE | ALU result valid; done pulse, writeback and apsr update
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [4:0] OP_CMP    = 5'd18;

    logic [1:0]        r_state;
    logic [4:0]        r_op;
    logic [IDX_W-1:0]  r_rd;
    logic              r_illegal;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [3:0]        r_apsr;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_issue;
    logic              w_capture;
    logic              w_req_illegal;
    logic              w_wb_en;
    logic [DATA_W-1:0] w_opb;

    assign w_issue       = (r_state == S_ISSUE);
    assign w_capture     = (r_state == S_CAPTURE);
    assign w_req_illegal = (req_op == 5'd0) || (req_op > OP_CMP);
    assign w_wb_en       = w_capture && !r_illegal && (r_op != OP_CMP);

`ifdef ALU_ISSUE_IMM_EN
    assign w_opb = req_imm_en ? {{(DATA_W-8){1'b0}}, req_imm} : r_regs[req_rm];
`else
    logic w_unused_imm;
    assign w_unused_imm = ^{req_imm_en, req_imm};
    assign w_opb        = r_regs[req_rm];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_apsr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_rd      <= req_rd;
                        r_illegal <= w_req_illegal;
                        r_opa     <= r_regs[req_rn];
                        r_opb     <= w_opb;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (!r_illegal) r_apsr <= alu_flags;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The ALU writeback is the later assignment, so it wins over a same-edge external write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (wr_en) r_regs[wr_addr] <= wr_data;
            if (w_wb_en) r_regs[r_rd] <= alu_result;
        end
    end

    // Instruction 0 outside ISSUE keeps the ALU flags (and carry) stable between ops.
    assign alu_instruction = (w_issue && !r_illegal) ? r_op : 5'd0;
    assign alu_num1        = w_issue ? r_opa : '0;
    assign alu_num2        = w_issue ? r_opb : '0;

    assign req_ready  = (r_state == S_IDLE);
    assign done_valid = w_capture;
    assign done_rd    = w_capture ? r_rd : '0;
    assign done_data  = w_capture ? alu_result : '0;
    assign done_err   = w_capture && r_illegal;
    assign apsr       = r_apsr;
    assign dbg_data   = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a registered ALU stand-in plus a register-file/flags scoreboard.
// Compile with the same ALU_ISSUE_IMM_EN setting as the design.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [2:0]  req_rd = '0, req_rn = '0, req_rm = '0;
    logic        req_imm_en = 1'b0;
    logic [7:0]  req_imm = '0;
    logic [4:0]  alu_instruction;
    logic [31:0] alu_num1, alu_num2;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        done_valid;
    logic [2:0]  done_rd;
    logic [31:0] done_data;
    logic        done_err;
    logic [3:0]  apsr;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [8];
    logic [3:0]  m_flags;
    logic [3:0]  m_apsr;
    logic [31:0] m_last;

    alu_issue_ctrl #(.NREGS(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_imm_en(req_imm_en), .req_imm(req_imm),
        .alu_instruction(alu_instruction), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data), .done_err(done_err),
        .apsr(apsr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stand-in: returns {flags, result}; flags are {V,C,Z,N}, logical ops keep C and V.
    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [3:0] f);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v, arith, is_sub, setf;
        c = f[2]; v = f[3]; arith = 1'b0; is_sub = 1'b0; setf = 1'b1; s = '0; r = '0;
        case (op)
            5'd1:  begin s = {1'b0, a} + {1'b0, b};                 arith = 1'b1; end
            5'd2:  begin s = {1'b0, a} + {1'b0, b} + {32'd0, f[2]};  arith = 1'b1; end
            5'd3:  begin s = {1'b0, a} + {1'b0, ~b} + 33'd1;         arith = 1'b1; is_sub = 1'b1; end
            5'd4:  begin s = {1'b0, a} + {1'b0, ~b} + {32'd0, f[2]}; arith = 1'b1; is_sub = 1'b1; end
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = a & ~b;
            5'd9:  r = ~b;
            5'd10: r = a << b[4:0];
            5'd11: r = a >> b[4:0];
            5'd12: r = a * b;
            5'd13: r = b;
            5'd14: begin r = a + b; setf = 1'b0; end
            5'd15: begin r = a - b; setf = 1'b0; end
            5'd16: begin r = a & b; setf = 1'b0; end
            5'd17: begin r = b;     setf = 1'b0; end
            5'd18: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1;         arith = 1'b1; is_sub = 1'b1; end
            default: setf = 1'b0;
        endcase
        if (arith) begin
            r = s[31:0];
            c = s[32];
            v = is_sub ? ((a[31] != b[31]) && (r[31] != a[31]))
                       : ((a[31] == b[31]) && (r[31] != a[31]));
        end
        return {(setf ? {v, c, (r == 32'd0), r[31]} : f), r};
    endfunction

    // Registered ALU: instruction 0 holds both result and flags.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            alu_flags  <= '0;
        end else if (alu_instruction != 5'd0) begin
            {alu_flags, alu_result} <= alu_model(alu_instruction, alu_num1, alu_num2, alu_flags);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_flags = '0; m_apsr = '0; m_last = '0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_regs[addr] = data;
        @(negedge clk);
    endtask

    // One full op from accept to writeback; optional external write during the CAPTURE cycle.
    task automatic do_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic imm_en, input logic [7:0] imm,
                         input logic cw_en, input logic [2:0] cw_addr, input logic [31:0] cw_data);
        logic [31:0] a, b, exp_res;
        logic [35:0] r;
        logic [3:0]  exp_f;
        logic        legal;
        int          n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_wait", {31'd0, req_ready}, 32'd1);
        legal = (op >= 5'd1) && (op <= 5'd18);
        a = m_regs[rn];
        b = m_regs[rm];
`ifdef ALU_ISSUE_IMM_EN
        if (imm_en) b = {24'd0, imm};
`endif
        r = alu_model(op, a, b, m_flags);
        exp_res = legal ? r[31:0] : m_last;
        exp_f   = legal ? r[35:32] : m_flags;
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rn = rn; req_rm = rm;
        req_imm_en = imm_en; req_imm = imm;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 5'($urandom); req_rd = 3'($urandom); req_rn = 3'($urandom);
        req_rm = 3'($urandom); req_imm_en = 1'($urandom); req_imm = 8'($urandom);
        @(negedge clk);
        check("issue_instr", {27'd0, alu_instruction}, legal ? {27'd0, op} : 32'd0);
        check("issue_num1", alu_num1, a);
        check("issue_num2", alu_num2, b);
        check("issue_ready", {31'd0, req_ready}, 32'd0);
        check("issue_nodone", {31'd0, done_valid}, 32'd0);
        @(negedge clk);
        check("done_valid", {31'd0, done_valid}, 32'd1);
        check("done_rd", {29'd0, done_rd}, {29'd0, rd});
        check("done_data", done_data, exp_res);
        check("done_err", {31'd0, done_err}, {31'd0, !legal});
        if (cw_en) begin wr_en = 1'b1; wr_addr = cw_addr; wr_data = cw_data; end
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (cw_en) m_regs[cw_addr] = cw_data;
        if (legal) begin
            m_flags = exp_f; m_apsr = exp_f; m_last = exp_res;
            if (op != 5'd18) m_regs[rd] = exp_res;
        end
        @(negedge clk);
        check("post_nodone", {31'd0, done_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
        check("apsr", {28'd0, apsr}, {28'd0, m_apsr});
        check_reg("wb_rd", rd, m_regs[rd]);
        if (cw_en) check_reg("wb_ext", cw_addr, m_regs[cw_addr]);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done_valid}, 32'd0);
        check("rst_done_data", done_data, 32'd0);
        check("rst_done_err", {31'd0, done_err}, 32'd0);
        check("rst_apsr", {28'd0, apsr}, 32'd0);
        check("rst_instr", {27'd0, alu_instruction}, 32'd0);
        check("rst_num1", alu_num1, 32'd0);
        for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ORRS r3 = r1 | r2
        ext_write(3'd1, 32'h0000_000F);
        ext_write(3'd2, 32'h0000_00F0);
        do_op(5'd6, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("orrs_r3", 3'd3, 32'h0000_00FF);
        check("orrs_apsr", {28'd0, apsr}, 32'd0);

        // SUBS 5-5, then CMP leaves rd alone
        ext_write(3'd1, 32'd5);
        ext_write(3'd2, 32'd5);
        ext_write(3'd5, 32'hA5A5_0005);
        do_op(5'd3, 3'd4, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("subs_r4", 3'd4, 32'd0);
        check("subs_apsr", {28'd0, apsr}, 32'b0110);
        do_op(5'd18, 3'd5, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("cmp_r5", 3'd5, 32'hA5A5_0005);
        check("cmp_apsr", {28'd0, apsr}, 32'b0110);

        // ADDS carry-out, then ADCS consumes it after idle cycles
        ext_write(3'd1, 32'hFFFF_FFFF);
        ext_write(3'd2, 32'd1);
        do_op(5'd1, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("adds_r3", 3'd3, 32'd0);
        check("adds_apsr", {28'd0, apsr}, 32'b0110);
        ext_write(3'd1, 32'd0);
        ext_write(3'd2, 32'd0);
        repeat (4) @(negedge clk);
        do_op(5'd2, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("adcs_r3", 3'd3, 32'd1);

        // Illegal opcodes
        ext_write(3'd1, 32'd7);
        ext_write(3'd2, 32'd9);
        do_op(5'd3, 3'd6, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        do_op(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("ill0_r3", 3'd3, 32'd1);
        do_op(5'd25, 3'd3, 3'd1, 3'd2, 1'b0, 8'd0, 1'b0, 3'd0, 32'd0);
        check_reg("ill25_r3", 3'd3, 32'd1);

        // Immediate operand
        ext_write(3'd1, 32'h10);
        ext_write(3'd2, 32'h7);
        do_op(5'd1, 3'd6, 3'd1, 3'd2, 1'b1, 8'h22, 1'b0, 3'd0, 32'd0);
`ifdef ALU_ISSUE_IMM_EN
        check_reg("imm_r6", 3'd6, 32'h32);
`else
        check_reg("imm_r6", 3'd6, 32'h17);
`endif

        // External write colliding with the CAPTURE writeback
        do_op(5'd13, 3'd4, 3'd1, 3'd2, 1'b0, 8'd0, 1'b1, 3'd4, 32'hDEAD_BEEF);
        check_reg("collide_r4", 3'd4, 32'h7);
        do_op(5'd13, 3'd5, 3'd1, 3'd1, 1'b0, 8'd0, 1'b1, 3'd0, 32'h1234_5678);
        check_reg("side_r0", 3'd0, 32'h1234_5678);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            if ($urandom_range(0, 3) == 0) ext_write(3'($urandom_range(0, 7)), $urandom);
            if (i % 6 == 0)       op = 5'($urandom_range(19, 31));
            else if (i % 11 == 0) op = 5'd0;
            else                  op = 5'($urandom_range(1, 18));
            do_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $urandom);
        end

        // Reset during ISSUE
        ext_write(3'd1, 32'h1234);
        ext_write(3'd2, 32'h5);
        req_valid = 1'b1; req_op = 5'd1; req_rd = 3'd7; req_rn = 3'd1; req_rm = 3'd2;
        req_imm_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_issue_instr", {27'd0, alu_instruction}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_done", {31'd0, done_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_instr", {27'd0, alu_instruction}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_nodone", {31'd0, done_valid}, 32'd0);
        end
        check("mid_rst_apsr", {28'd0, apsr}, 32'd0);
        for (int i = 0; i < 8; i++) check_reg("mid_rst_reg", 3'(i), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
